// File: rtl/fir_gain_div_pkg.sv
// Shared widths, saturation bounds and FSM state type for the FIR gain divider.
package fir_gain_div_pkg;

    localparam int DEF_DIVIDEND_W = 28;
    localparam int DEF_DIVISOR_W  = 12;
    localparam int DEF_QUOT_W     = 16;

    localparam int QUOT_MAX = 32767;
    localparam int QUOT_MIN = -32768;

    localparam int ITER_CNT = DEF_DIVIDEND_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fir_gain_div_post.sv
// Combinational finishing stage: signs, optional rounding, saturation, divide-by-zero.
// Rounding (half away from zero) is enabled by defining FIR_GAIN_DIV_ROUND_EN.
module fir_gain_div_post
    import fir_gain_div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W,
    parameter int QUOT_W     = DEF_QUOT_W
) (
    input  logic [DIVIDEND_W-1:0] q_mag,
    input  logic [DIVISOR_W-1:0]  r_mag,
    input  logic [DIVISOR_W:0]    d_mag,
    input  logic                  sign_q,
    input  logic                  sign_r,
    output logic [QUOT_W-1:0]     quot,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  ovf
);

    // One extra bit for the rounding carry, one for the sign.
    localparam int QF_W = DIVIDEND_W + 2;
    localparam logic signed [QF_W-1:0] Q_HI = (QF_W'(1) << (QUOT_W - 1)) - QF_W'(1);
    localparam logic signed [QF_W-1:0] Q_LO = -(QF_W'(1) << (QUOT_W - 1));

    logic                   zero_div;
    logic                   round_up;
    logic [DIVIDEND_W:0]    mag_adj;
    logic signed [QF_W-1:0] q_full;
    logic [DIVISOR_W-1:0]   r_sel;
    logic                   r_neg;

    always_comb begin
        zero_div = (d_mag == '0);
        round_up = 1'b0;
`ifdef FIR_GAIN_DIV_ROUND_EN
        round_up = !zero_div && ({1'b0, r_mag, 1'b0} >= {1'b0, d_mag});
`endif
        mag_adj = {1'b0, q_mag} + {{DIVIDEND_W{1'b0}}, round_up};
        q_full  = sign_q ? -$signed({1'b0, mag_adj}) : $signed({1'b0, mag_adj});

        // Rounding moves the quotient one step away from zero, so the remainder
        // becomes |d|-|r| with the opposite sign to keep din0 = q*din1 + rem.
        r_sel = round_up ? DIVISOR_W'(d_mag - {1'b0, r_mag}) : r_mag;
        r_neg = sign_r ^ round_up;

        quot = '0;
        rem  = '0;
        ovf  = 1'b0;
        if (zero_div) begin
            quot = sign_r ? Q_LO[QUOT_W-1:0] : Q_HI[QUOT_W-1:0];
        end else begin
            rem = r_neg ? -r_sel : r_sel;
            if (q_full > Q_HI) begin
                quot = Q_HI[QUOT_W-1:0];
                ovf  = 1'b1;
            end else if (q_full < Q_LO) begin
                quot = Q_LO[QUOT_W-1:0];
                ovf  = 1'b1;
            end else begin
                quot = q_full[QUOT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fir_gain_div_28s_12s_16.sv
// Sequential signed restoring divider 28s / 12s -> saturated 16s quotient plus remainder.
// Optional round-half-away-from-zero via FIR_GAIN_DIV_ROUND_EN (see fir_gain_div_post).
module fir_gain_div_28s_12s_16
    import fir_gain_div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W,
    parameter int QUOT_W     = DEF_QUOT_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quot,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  ovf,
    output logic                  dbz
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    state_t state, state_next;
    logic   accept, step, finish, release_out;

    // Dividend magnitude shifts out MSB-first while quotient bits shift in at the LSB.
    logic [DIVIDEND_W-1:0] dvd;
    logic [DIVISOR_W:0]    dvs;
    logic [DIVISOR_W:0]    pr;
    logic [CNT_W-1:0]      cnt;
    logic                  sign_q, sign_r, dbz_lat;

    logic [DIVIDEND_W-1:0] din0_mag;
    logic [DIVISOR_W:0]    din1_ext, din1_mag;
    logic [DIVISOR_W+1:0]  trial, diff;
    logic                  q_bit;
    logic [DIVISOR_W:0]    pr_next;

    logic [QUOT_W-1:0]     post_quot;
    logic [DIVISOR_W-1:0]  post_rem;
    logic                  post_ovf;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        accept      = 1'b0;
        step        = 1'b0;
        finish      = 1'b0;
        release_out = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == '0) state_next = FIN;
            end
            FIN: begin
                finish     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The 13-bit divisor magnitude absorbs |-2048| without special-casing.
    always_comb begin
        din0_mag = din0[DIVIDEND_W-1] ? -din0 : din0;
        din1_ext = {din1[DIVISOR_W-1], din1};
        din1_mag = din1[DIVISOR_W-1] ? -din1_ext : din1_ext;
    end

    always_comb begin
        trial   = {pr, dvd[DIVIDEND_W-1]};
        diff    = trial - {1'b0, dvs};
        q_bit   = !diff[DIVISOR_W+1];
        pr_next = q_bit ? diff[DIVISOR_W:0] : trial[DIVISOR_W:0];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dvd       <= '0;
            dvs       <= '0;
            pr        <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dbz_lat   <= 1'b0;
            quot      <= '0;
            rem       <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                dvd     <= din0_mag;
                dvs     <= din1_mag;
                pr      <= '0;
                cnt     <= CNT_W'(DIVIDEND_W - 1);
                sign_q  <= din0[DIVIDEND_W-1] ^ din1[DIVISOR_W-1];
                sign_r  <= din0[DIVIDEND_W-1];
                dbz_lat <= (din1 == '0);
            end
            if (step) begin
                pr  <= pr_next;
                dvd <= {dvd[DIVIDEND_W-2:0], q_bit};
                if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end
            if (finish) begin
                quot      <= post_quot;
                rem       <= post_rem;
                ovf       <= post_ovf;
                dbz       <= dbz_lat;
                out_valid <= 1'b1;
            end
            if (release_out) out_valid <= 1'b0;
        end
    end

    // pr < |divisor| <= 2048 after the last step, so its low DIVISOR_W bits hold it.
    fir_gain_div_post #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W),
        .QUOT_W     (QUOT_W)
    ) u_post (
        .q_mag  (dvd),
        .r_mag  (pr[DIVISOR_W-1:0]),
        .d_mag  (dvs),
        .sign_q (sign_q),
        .sign_r (sign_r),
        .quot   (post_quot),
        .rem    (post_rem),
        .ovf    (post_ovf)
    );

endmodule

// File: tb/tb_fir_gain_div_28s_12s_16.sv
// Self-checking bench for fir_gain_div_28s_12s_16: integer-arithmetic model plus literal vectors.
module tb_fir_gain_div_28s_12s_16;
    import fir_gain_div_pkg::*;

`ifdef FIR_GAIN_DIV_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    localparam int LATENCY = ITER_CNT + 1;

    logic        clk = 1'b0;
    logic        ap_rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] din0 = '0;
    logic [11:0] din1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quot;
    logic [11:0] rem;
    logic        ovf;
    logic        dbz;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        longint q;
        longint r;
        bit     ov;
        bit     dz;
        int     hs;
    } exp_t;

    exp_t expq[$];
    exp_t cur;
    bit   have_cur = 1'b0;

    fir_gain_div_28s_12s_16 dut (
        .ap_clk    (clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint labs(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    // C-style division, optional half-away rounding, then clip to 16 bits.
    function automatic exp_t model(input longint a, input longint b);
        exp_t   e;
        longint s;
        e.hs = 0;
        if (b == 0) begin
            e.q  = (a >= 0) ? longint'(QUOT_MAX) : longint'(QUOT_MIN);
            e.r  = 0;
            e.ov = 1'b0;
            e.dz = 1'b1;
            return e;
        end
        e.q  = a / b;
        e.r  = a % b;
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (RND && (2 * labs(e.r) >= labs(b))) begin
            s   = ((a < 0) != (b < 0)) ? -1 : 1;
            e.q = e.q + s;
            e.r = e.r - s * b;
        end
        if (e.q > QUOT_MAX) begin
            e.q  = QUOT_MAX;
            e.ov = 1'b1;
        end else if (e.q < QUOT_MIN) begin
            e.q  = QUOT_MIN;
            e.ov = 1'b1;
        end
        return e;
    endfunction

    // Compare process: model at every handshake, check every cycle a result is presented.
    always @(negedge clk) begin
        if (!ap_rst_n) begin
            expq.delete();
            have_cur = 1'b0;
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_quot", longint'($signed(quot)), 0);
            check("rst_rem", longint'($signed(rem)), 0);
            check("rst_ovf", ovf, 0);
            check("rst_dbz", dbz, 0);
        end else begin
            if (in_valid && in_ready) begin
                exp_t e;
                e    = model(longint'($signed(din0)), longint'($signed(din1)));
                e.hs = cyc;
                expq.push_back(e);
            end
            if (out_valid) begin
                if (!have_cur) begin
                    if (expq.size() == 0) begin
                        check("spurious_out_valid", 1, 0);
                    end else begin
                        cur      = expq.pop_front();
                        have_cur = 1'b1;
                        check("latency", cyc - cur.hs - 1, LATENCY);
                    end
                end
                if (have_cur) begin
                    check("quot", longint'($signed(quot)), cur.q);
                    check("rem", longint'($signed(rem)), cur.r);
                    check("ovf", ovf, longint'(cur.ov));
                    check("dbz", dbz, longint'(cur.dz));
                    check("busy_in_ready", in_ready, 0);
                end
            end else begin
                have_cur = 1'b0;
            end
        end
    end

    task automatic issue(input longint a, input longint b);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check("issue_timeout", 0, 1);
            return;
        end
        din0     = a[27:0];
        din1     = b[11:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input longint a, input longint b,
                           input longint qt, input longint rt,
                           input longint qr, input longint rr,
                           input bit ov, input bit dz, input int hold);
        int n;
        issue(a, b);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            check("result_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        check("lit_quot", longint'($signed(quot)), RND ? qr : qt);
        check("lit_rem", longint'($signed(rem)), RND ? rr : rt);
        check("lit_ovf", ovf, longint'(ov));
        check("lit_dbz", dbz, longint'(dz));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        #1 ap_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 ap_rst_n = 1'b1;

        //       din0        din1   q_trunc r_trunc q_round r_round ovf dbz hold
        run_vec( 1000,       7,     142,    6,      143,    -1,     0,  0,  0);
        run_vec(-1000,       7,    -142,   -6,     -143,     1,     0,  0,  0);
        run_vec( 1000,      -7,    -142,    6,     -143,    -1,     0,  0,  0);
        run_vec( 7,          2,     3,      1,      4,      -1,     0,  0,  0);
        run_vec(-7,          2,    -3,     -1,     -4,       1,     0,  0,  0);
        run_vec(-134217728, -1,     32767,  0,      32767,   0,     1,  0,  0);
        run_vec( 134217727,  2047,  32767,  31,     32767,   31,    1,  0,  0);
        run_vec(-5,          0,    -32768,  0,     -32768,   0,     0,  1,  0);
        run_vec(-4096,      -2048,  2,      0,      2,       0,     0,  0,  0);
        run_vec(-65536,      2,    -32768,  0,     -32768,   0,     0,  0,  0);
        run_vec( 65536,      2,     32767,  0,      32767,   0,     1,  0,  0);
        run_vec( 12345,     -2048, -6,      57,    -6,       57,    0,  0,  10);
        run_vec( 100000,     3,     32767,  1,      32767,   1,     1,  0,  0);

        // Abort a division mid-CALC with an asynchronous reset.
        issue(5000, 3);
        repeat (10) @(posedge clk);
        #2 ap_rst_n = 1'b0;
        #1;
        check("async_in_ready", in_ready, 1);
        check("async_out_valid", out_valid, 0);
        check("async_quot", longint'($signed(quot)), 0);
        check("async_rem", longint'($signed(rem)), 0);
        check("async_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #2 ap_rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("post_reset_out_valid", out_valid, 0);
        run_vec(-30000,      123,  -243,   -111,   -244,    12,     0,  0,  0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish before 1000000");
        $fatal(1);
    end

endmodule
